// File: rtl/wb_cache_top.sv
// Direct-mapped write-back, write-allocate data cache with line-wide memory port.
// Misses stall the CPU while an optional dirty write-back and a refill complete.
module wb_cache_top #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int INDEX_W        = 5,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        cpu_rd,
  input  logic                                        cpu_wr,
  input  logic [ADDR_W-1:0]                           cpu_addr,
  input  logic [DATA_W-1:0]                           cpu_wdata,
  output logic [DATA_W-1:0]                           cpu_rdata,
  output logic                                        stall,
  output logic                                        mem_req,
  output logic                                        mem_we,
  output logic [ADDR_W-$clog2(WORDS_PER_LINE)-1:0]    mem_addr,
  output logic [DATA_W*WORDS_PER_LINE-1:0]            mem_wline,
  input  logic [DATA_W*WORDS_PER_LINE-1:0]            mem_rline,
  input  logic                                        mem_ready,
  output logic [CNT_W-1:0]                            access_cnt,
  output logic [CNT_W-1:0]                            miss_cnt
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  // Handshake: a memory transaction completes at the rising edge where
  // mem_req & mem_ready are both high; mem_ready with mem_req low is ignored.
  state_t state_q, state_d;

  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W-1:0] cpu_index;
  logic [OFF_W-1:0]   cpu_off;
  logic               req, hit, fill_en, write_en, miss_inc;

  logic [LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [DATA_W-1:0]  data_mem [LINES][WORDS_PER_LINE];

  assign cpu_tag   = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_index = cpu_addr[OFF_W +: INDEX_W];
  assign cpu_off   = cpu_addr[OFF_W-1:0];
  assign req       = cpu_rd | cpu_wr;
  assign hit       = valid_q[cpu_index] && (tag_mem[cpu_index] == cpu_tag);

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wline = '0;
    cpu_rdata = '0;
    fill_en   = 1'b0;
    write_en  = 1'b0;
    miss_inc  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              write_en = cpu_wr;
              if (cpu_rd) cpu_rdata = data_mem[cpu_index][cpu_off];
            end else begin
              stall = 1'b1;
              if (valid_q[cpu_index] && dirty_q[cpu_index]) begin
                state_d = WRITEBACK;
              end else begin
                state_d  = REFILL;
                miss_inc = 1'b1;
              end
            end
          end
        end
        WRITEBACK: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_addr = {tag_mem[cpu_index], cpu_index};
          for (int w = 0; w < WORDS_PER_LINE; w++)
            mem_wline[w*DATA_W +: DATA_W] = data_mem[cpu_index][w];
          if (mem_ready) begin
            state_d  = REFILL;
            miss_inc = 1'b1;
          end
        end
        REFILL: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {cpu_tag, cpu_index};
          if (mem_ready) begin
            fill_en = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      access_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (miss_inc) miss_cnt <= miss_cnt + CNT_W'(1);
      if (req && !stall) access_cnt <= access_cnt + CNT_W'(1);
      if (fill_en) begin
        valid_q[cpu_index] <= 1'b1;
        dirty_q[cpu_index] <= 1'b0;
      end
      if (write_en) dirty_q[cpu_index] <= 1'b1;
    end
  end

  // Tags and line data carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[cpu_index] <= cpu_tag;
      for (int w = 0; w < WORDS_PER_LINE; w++)
        data_mem[cpu_index][w] <= mem_rline[w*DATA_W +: DATA_W];
    end else if (write_en) begin
      data_mem[cpu_index][cpu_off] <= cpu_wdata;
    end
  end
endmodule

// File: doc/wb_cache_top.md
# wb_cache_top

Parametrised direct-mapped, write-back, write-allocate data cache with an embedded controller. It sits between the CPU data port and a line-wide backing memory. It is the successor to the fixed-size write-through cache top, and adds:
- configurable geometry,
- dirty-line eviction,
- a req/ready memory handshake,
- access/miss counters.

## Interface
Parameters:
- ADDR_W, 10, CPU word-address width
- DATA_W, 32, word width
- INDEX_W, 5, index bits (2^INDEX_W lines)
- WORDS_PER_LINE, 4, words per line, power of two ≥ 2; OFF_W = log2(WORDS_PER_LINE), TAG_W = ADDR_W − INDEX_W − OFF_W ≥ 1
- CNT_W, 16, counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_rd  in  1  read request
- cpu_wr  in  1  write request; wins if both asserted
- cpu_addr  in  ADDR_W  word address {tag, index, offset}
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid when cpu_rd & !stall
- stall  out  1  CPU must hold request stable while high
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = line write-back, 0 = line fill
- mem_addr  out  ADDR_W−OFF_W  line address {tag, index}
- mem_wline  out  DATA_W·WORDS_PER_LINE  victim line, word 0 in LSBs
- mem_rline  in  DATA_W·WORDS_PER_LINE  fill line, word 0 in LSBs
- mem_ready  in  1  transaction completes at the edge where mem_req & mem_ready
- access_cnt  out  CNT_W  completed CPU accesses
- miss_cnt  out  CNT_W  refills started

## Operation
Per-line storage:
- valid bit
- dirty bit
- TAG_W tag
- line data

Hit = valid[index] & tag match.

FSM states: IDLE, WRITEBACK, REFILL.
- IDLE, no request: nothing happens.
- IDLE, read hit: cpu_rdata = word[offset], combinational.
- IDLE, write hit: word[offset] ← cpu_wdata and dirty ← 1 at the edge.
- IDLE, miss with victim valid & dirty: → WRITEBACK.
- IDLE, any other miss: → REFILL. miss_cnt increments on entry to REFILL.
- WRITEBACK:
  - mem_req=1, mem_we=1.
  - mem_addr = {stored tag, index}, mem_wline = stored line.
  - On mem_ready: → REFILL and miss_cnt++.
- REFILL:
  - mem_req=1, mem_we=0.
  - mem_addr = {cpu tag, index}.
  - On mem_ready: line ← mem_rline, tag ← cpu tag, valid ← 1, dirty ← 0; → IDLE.
- Back in IDLE, the held request re-evaluates as a hit. Write-allocate: a write miss completes as a write hit after the fill.

Output rules:
- stall = !rst & (state ≠ IDLE | ((cpu_rd|cpu_wr) & !hit)).
- cpu_rdata = 0 unless cpu_rd & hit & state = IDLE.
- mem_we, mem_addr and mem_wline are don't-care when mem_req=0. The implementation drives 0.
- access_cnt increments in every cycle where (cpu_rd|cpu_wr) & !stall.
- Counters wrap modulo 2^CNT_W.

## Timing
- Hit: 0-cycle latency, stall never asserted.
- Clean miss: request seen in cycle 0, and stall=1 in that same cycle. mem_req rises in cycle 1. If mem_ready arrives in cycle k, the fill is written at the end of cycle k and stall=0 in cycle k+1 with data valid.
- Dirty miss: write-back transaction, then refill transaction. mem_req stays high between them: the refill request starts the cycle after write-back ready.
- mem_ready may be a level or a pulse. Only edges with mem_req high are consumed. mem_ready while mem_req=0 is ignored.
- CPU address or data changes while stall=1 are illegal. Behaviour is unspecified.
- Reset (any state, including mid-transaction):
  - At the next edge: state=IDLE, all valid and dirty cleared, counters=0.
  - Outputs while rst=1: stall=0, mem_req=0, cpu_rdata=0.
  - A pending memory transaction is abandoned. Memory must tolerate mem_req dropping.
- Line data and tags are not reset.

## Test plan
- **Cold read miss.** After reset, read 0x004 with memory ready 3 cycles after mem_req:
  - stall=1 from cycle 0.
  - mem_req=1, mem_we=0, mem_addr=0x01.
  - Return line {0x33,0x22,0x11,0x00} (word 0 = 0x00). Stall drops the cycle after the ready edge and cpu_rdata=0x00.
  - Then read 0x006 → no stall, cpu_rdata=0x22.
  - access_cnt=2, miss_cnt=1.
- **Write hit.** Write 0x005 with 0xDEADBEEF → stall=0, no mem_req, dirty set. Read 0x005 → 0xDEADBEEF.
- **Dirty eviction.** Read 0x084 (same index, tag 1):
  - First transaction: mem_we=1, mem_addr=0x01, mem_wline word1=0xDEADBEEF.
  - Second transaction: mem_we=0, mem_addr=0x21.
  - Then data is returned; miss_cnt increments once.
- **Write miss, clean victim.**
  - Write 0x100 with 0xA5A5A5A5 → refill only, then write applied and dirty set.
  - A later conflicting access to 0x000 (same index 0, different tag) triggers write-back with word0=0xA5A5A5A5.
- **Reset during REFILL.** Assert rst with mem_req high:
  - mem_req=0, stall=0 while rst=1.
  - After release, reading the previously cached 0x006 misses again.
  - Counters restart at 0.
- **Geometry and wrap.** INDEX_W=3, WORDS_PER_LINE=8, CNT_W=4:
  - Read 0x0FF → mem_addr=0x1F, word 7 returned.
  - 16 hits wrap access_cnt to 0.
